// File: rtl/ps2_rx_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_rx_multi: NPORTS filtered PS/2 receivers with per-port FIFOs on SPAM.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ps2_rx_multi #(
  parameter int NPORTS          = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int SPAM_DID_HI     = 3,
  parameter int SPAM_ADDR_HI    = 23,
  parameter int SPAM_DATA_HI    = 31,
  parameter logic [SPAM_DID_HI:0]  SPAM_DID_KEYBOARD = 'h2,
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRPFX      = '0,
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRMASK     = '0,
  parameter logic [SPAM_DID_HI:0]  SPAM_DID          = SPAM_DID_KEYBOARD
) (
  input  logic                    cclk,
  input  logic                    cclk_rst_b,
  input  logic [NPORTS-1:0]       ps2clk,
  input  logic [NPORTS-1:0]       ps2data,
  input  logic                    spamo_valid,
  input  logic                    spamo_r_nw,
  input  logic [SPAM_DID_HI:0]    spamo_did,
  input  logic [SPAM_ADDR_HI:0]   spamo_addr,
  input  logic [SPAM_DATA_HI:0]   spamo_data,
  output logic                    ps2__spami_busy_b,
  output logic [31:0]             ps2__spami_data,
  output logic [NPORTS-1:0]       ps2__irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic              w_hit;
  logic [1:0]        w_port;
  logic [1:0]        w_reg;
  logic [NPORTS-1:0] w_pop;
  logic [NPORTS-1:0] w_clr;
  logic [CW-1:0]     w_cnt  [NPORTS];
  logic [7:0]        w_head [NPORTS];
  logic [7:0]        w_ferr [NPORTS];
  logic [7:0]        w_perr [NPORTS];
  logic              w_ovf  [NPORTS];
  logic [31:0]       rdata_d;
  logic              w_unused;

  assign w_hit    = spamo_valid && (spamo_did == SPAM_DID) &&
                    ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);
  assign w_port   = spamo_addr[5:4];
  assign w_reg    = spamo_addr[3:2];
  assign w_unused = ^spamo_data[SPAM_DATA_HI:1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, filt_q;
    logic [DW-1:0] deb_q;
    logic          w_fall;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d, pbyte_q, pbyte_d, ferr_q, perr_q;
    logic          par_q, par_d, push_q, push_d, w_perr_inc, w_ferr_inc;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q, w_full, w_wr;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // Filtered clock only follows the synchroniser once the new level has
    // survived DEBOUNCE_CYCLES cycles; the fall is flagged in that cycle.
    assign w_fall = filt_q && !clk_s2_q && (deb_q == DW'(DEBOUNCE_CYCLES));

    always_ff @(posedge cclk or negedge cclk_rst_b) begin
      if (!cclk_rst_b) begin
        clk_s1_q <= 1'b1;
        clk_s2_q <= 1'b1;
        dat_s1_q <= 1'b1;
        dat_s2_q <= 1'b1;
        filt_q   <= 1'b1;
        deb_q    <= '0;
      end else begin
        clk_s1_q <= ps2clk[p];
        clk_s2_q <= clk_s1_q;
        dat_s1_q <= ps2data[p];
        dat_s2_q <= dat_s1_q;
        if (clk_s2_q == filt_q) begin
          deb_q <= '0;
        end else if (deb_q == DW'(DEBOUNCE_CYCLES)) begin
          filt_q <= clk_s2_q;
          deb_q  <= '0;
        end else begin
          deb_q <= deb_q + 1'b1;
        end
      end
    end

    always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      par_d      = par_q;
      push_d     = 1'b0;
      pbyte_d    = pbyte_q;
      w_perr_inc = 1'b0;
      w_ferr_inc = 1'b0;
      tmo_d      = (state_q == ST_IDLE || w_fall) ? '0 : tmo_q + 1'b1;
      case (state_q)
        ST_IDLE: if (w_fall && !dat_s2_q) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
        ST_DATA: if (w_fall) begin
          sh_d  = {dat_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: if (w_fall) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: if (w_fall) begin
          state_d = ST_IDLE;
          if (!dat_s2_q)              w_ferr_inc = 1'b1;
          else if (!(^sh_q ^ par_q))  w_perr_inc = 1'b1;
          else begin
            push_d  = 1'b1;
            pbyte_d = sh_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && !w_fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = ST_IDLE;
        w_ferr_inc = 1'b1;
        tmo_d      = '0;
      end
    end

    assign w_full = (cnt_q == CW'(FIFO_DEPTH));
    assign w_wr   = push_q && !w_full;
    assign w_pop[p] = w_hit && spamo_r_nw && (w_reg == 2'd0) &&
                      (w_port == 2'(p)) && (cnt_q != '0);
    assign w_clr[p] = w_hit && !spamo_r_nw && (w_reg == 2'd2) &&
                      (w_port == 2'(p)) && spamo_data[0];

    always_ff @(posedge cclk or negedge cclk_rst_b) begin
      if (!cclk_rst_b) begin
        state_q <= ST_IDLE;
        bit_q   <= '0;
        sh_q    <= '0;
        par_q   <= 1'b0;
        tmo_q   <= '0;
        push_q  <= 1'b0;
        pbyte_q <= '0;
        ferr_q  <= '0;
        perr_q  <= '0;
        ovf_q   <= 1'b0;
        wr_q    <= '0;
        rd_q    <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        bit_q   <= bit_d;
        sh_q    <= sh_d;
        par_q   <= par_d;
        tmo_q   <= tmo_d;
        push_q  <= push_d;
        pbyte_q <= pbyte_d;
        // A software clear outranks any same-cycle event.
        if (w_clr[p])                          ferr_q <= '0;
        else if (w_ferr_inc && ferr_q != 8'hFF) ferr_q <= ferr_q + 8'd1;
        if (w_clr[p])                          perr_q <= '0;
        else if (w_perr_inc && perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
        if (w_clr[p])                          ovf_q  <= 1'b0;
        else if (push_q && w_full)             ovf_q  <= 1'b1;
        if (w_wr)     wr_q <= wr_q + 1'b1;
        if (w_pop[p]) rd_q <= rd_q + 1'b1;
        if (w_wr && !w_pop[p])      cnt_q <= cnt_q + 1'b1;
        else if (!w_wr && w_pop[p]) cnt_q <= cnt_q - 1'b1;
      end
    end

    always_ff @(posedge cclk) begin
      if (w_wr) mem_q[wr_q] <= pbyte_q;
    end

    assign w_cnt[p]    = cnt_q;
    assign w_head[p]   = mem_q[rd_q];
    assign w_ferr[p]   = ferr_q;
    assign w_perr[p]   = perr_q;
    assign w_ovf[p]    = ovf_q;
    assign ps2__irq[p] = (cnt_q != '0);
  end

  always_comb begin
    rdata_d = '0;
    if (spamo_r_nw) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_port == 2'(i)) begin
          case (w_reg)
            2'd0: if (w_cnt[i] != '0) rdata_d = {1'b1, 23'h0, w_head[i]};
            2'd1: rdata_d = {8'h0, w_ferr[i], w_perr[i], w_ovf[i], 7'(w_cnt[i])};
            default: rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      ps2__spami_busy_b <= 1'b0;
      ps2__spami_data   <= '0;
    end else begin
      ps2__spami_busy_b <= w_hit;
      ps2__spami_data   <= w_hit ? rdata_d : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_multi.sv
`default_nettype none
// Directed bench for ps2_rx_multi: PS/2 frames in, SPAM reads checked against a scoreboard.
module tb_ps2_rx_multi;

  localparam int NP   = 2;
  localparam int FD   = 4;
  localparam int DEB  = 8;
  localparam int TMO  = 300;
  localparam int HALF = 30;
  localparam logic [3:0]  DID  = 4'h2;
  localparam logic [23:0] PFX  = 24'h00A000;
  localparam logic [23:0] MASK = 24'hFFF000;

  logic          cclk = 1'b0;
  logic          cclk_rst_b = 1'b0;
  logic [NP-1:0] ps2clk = '1;
  logic [NP-1:0] ps2data = '1;
  logic          spamo_valid = 1'b0;
  logic          spamo_r_nw = 1'b0;
  logic [3:0]    spamo_did = '0;
  logic [23:0]   spamo_addr = '0;
  logic [31:0]   spamo_data = '0;
  logic          busy_b;
  logic [31:0]   rdata;
  logic [NP-1:0] irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] rd;

  ps2_rx_multi #(
    .NPORTS(NP), .FIFO_DEPTH(FD), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO),
    .SPAM_DID_HI(3), .SPAM_ADDR_HI(23), .SPAM_DATA_HI(31),
    .SPAM_DID_KEYBOARD(DID), .SPAM_ADDRPFX(PFX), .SPAM_ADDRMASK(MASK), .SPAM_DID(DID)
  ) dut (
    .cclk(cclk), .cclk_rst_b(cclk_rst_b), .ps2clk(ps2clk), .ps2data(ps2data),
    .spamo_valid(spamo_valid), .spamo_r_nw(spamo_r_nw), .spamo_did(spamo_did),
    .spamo_addr(spamo_addr), .spamo_data(spamo_data),
    .ps2__spami_busy_b(busy_b), .ps2__spami_data(rdata), .ps2__irq(irq)
  );

  always #5 cclk = ~cclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge cclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input int p, input logic b, input bit gl);
    ps2data[p] = b;
    if (gl) begin
      cyc(10); ps2clk[p] = 1'b0; cyc(5); ps2clk[p] = 1'b1; cyc(HALF - 15);
    end else cyc(HALF);
    ps2clk[p] = 1'b0;
    if (gl) begin
      cyc(20); ps2clk[p] = 1'b1; cyc(5); ps2clk[p] = 1'b0; cyc(HALF - 25);
    end else cyc(HALF);
    ps2clk[p] = 1'b1;
  endtask

  task automatic send_frame(input int p, input logic [7:0] b, input logic badpar,
                            input logic stop, input bit gl, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(p, f[i], gl);
    cyc(DEB + 10);
  endtask

  task automatic send_good(input int p, input logic [7:0] b, input bit gl);
    if (p == 0) q0.push_back({1'b1, 23'h0, b});
    else        q1.push_back({1'b1, 23'h0, b});
    send_frame(p, b, 1'b0, 1'b1, gl, 11);
  endtask

  task automatic bus(input logic rnw, input int p, input int rg,
                     input logic [31:0] wd, output logic [31:0] r);
    logic [1:0] pp, rr;
    pp = 2'(p);
    rr = 2'(rg);
    @(negedge cclk);
    spamo_valid = 1'b1;
    spamo_r_nw  = rnw;
    spamo_did   = DID;
    spamo_addr  = PFX | {18'h0, pp, rr, 2'b00};
    spamo_data  = wd;
    @(negedge cclk);
    spamo_valid = 1'b0;
    chk("busy_b", {31'h0, busy_b}, 32'h1);
    r = rdata;
  endtask

  task automatic read_pop(input int p, input string tag);
    logic [31:0] exp;
    exp = 32'h0;
    if (p == 0 && q0.size() > 0) exp = q0.pop_front();
    if (p == 1 && q1.size() > 0) exp = q1.pop_front();
    bus(1'b1, p, 0, 32'h0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic status(input int p, input logic [31:0] exp, input string tag);
    bus(1'b1, p, 1, 32'h0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic clear(input int p);
    bus(1'b0, p, 2, 32'h1, rd);
  endtask

  initial begin
    cyc(3);
    chk("rst_busy", {31'h0, busy_b}, 32'h0);
    chk("rst_data", rdata, 32'h0);
    chk("rst_irq", {30'h0, irq}, 32'h0);
    cclk_rst_b = 1'b1;
    cyc(3);

    // Requests that miss the decode get no response.
    @(negedge cclk);
    spamo_valid = 1'b1; spamo_r_nw = 1'b1; spamo_did = 4'h5; spamo_addr = PFX | 24'h14;
    @(negedge cclk);
    spamo_valid = 1'b0;
    chk("miss_busy", {31'h0, busy_b}, 32'h0);
    chk("miss_data", rdata, 32'h0);

    send_good(0, 8'h1C, 1'b0);
    chk("irq0_set", {31'h0, irq[0]}, 32'h1);
    read_pop(0, "pop_1C");
    cyc(1);
    chk("irq0_clr", {31'h0, irq[0]}, 32'h0);
    read_pop(0, "pop_empty");

    send_frame(1, 8'hF0, 1'b1, 1'b1, 1'b0, 11);
    chk("irq1_badpar", {31'h0, irq[1]}, 32'h0);
    status(1, 32'h0000_0100, "stat1_perr");

    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0, 3);
    cyc(TMO + 10);
    status(0, 32'h0001_0000, "stat0_tmo");
    send_good(0, 8'h5A, 1'b0);
    read_pop(0, "pop_5A");

    clear(0);
    clear(1);
    status(1, 32'h0000_0000, "stat1_clr");
    for (int i = 0; i < FD; i++) send_good(0, 8'(8'h11 + i), 1'b0);
    send_frame(0, 8'h15, 1'b0, 1'b1, 1'b0, 11);
    status(0, 32'h0000_0084, "stat0_ovf");
    for (int i = 0; i < FD; i++) read_pop(0, "pop_ovf");
    read_pop(0, "pop_ovf_empty");

    send_good(1, 8'hA5, 1'b1);
    read_pop(1, "pop_glitch");
    status(1, 32'h0000_0000, "stat1_glitch");

    clear(0);
    send_frame(0, 8'h33, 1'b1, 1'b1, 1'b0, 11);
    for (int i = 0; i < FD - 1; i++) send_good(0, 8'(8'h21 + i), 1'b0);
    begin
      logic [10:0] f;
      f = {1'b1, ~^8'h24, 8'h24, 1'b0};
      q0.push_back({1'b1, 23'h0, 8'h24});
      for (int i = 0; i < 10; i++) ps2_bit(0, f[i], 1'b0);
      ps2data[0] = 1'b1;
      cyc(HALF);
      ps2clk[0] = 1'b0;
      cyc(DEB + 2);
      read_pop(0, "pop_concurrent");
      cyc(HALF);
      ps2clk[0] = 1'b1;
      cyc(DEB + 10);
    end
    status(0, 32'h0000_0103, "stat0_concurrent");
    clear(0);
    status(0, 32'h0000_0003, "stat0_cleared");
    for (int i = 0; i < FD - 1; i++) read_pop(0, "pop_drain");
    read_pop(0, "pop_drain_empty");

    bus(1'b1, 3, 1, 32'h0, rd);
    chk("oor_read", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
